// File: rtl/alu_pkg.sv
// Shared encodings for the ALU arbiter: opcode layout, main_sel values and FSM states.
package alu_pkg;

    localparam logic [1:0] MAIN_ARITH = 2'b00;
    localparam logic [1:0] MAIN_LOGIC = 2'b01;
    localparam logic [1:0] MAIN_SHR   = 2'b10;
    localparam logic [1:0] MAIN_SHL   = 2'b11;

    localparam int OP_W        = 5;
    localparam int OP_MAIN_LSB = 3;
    localparam int OP_SUB_LSB  = 1;
    localparam int OP_CIN_BIT  = 0;

    // Field order matches the packed request opcode {main_sel, sub_sel, cin}.
    typedef struct packed {
        logic [1:0] main_sel;
        logic [1:0] sub_sel;
        logic       cin;
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU: arithmetic, logic and single-bit shifts, result modulo 2^W.
module ALU
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_t          op,
    output logic [W-1:0] y
);

    logic [W-1:0] cin_w;

    assign cin_w = W'(op.cin);

    always_comb begin
        y = '0;
        case (op.main_sel)
            MAIN_ARITH: begin
                case (op.sub_sel)
                    2'b00:   y = a + cin_w;
                    2'b01:   y = a + b + cin_w;
                    2'b10:   y = a + ~b + cin_w;
                    default: y = a - W'(1) + cin_w;
                endcase
            end
            MAIN_LOGIC: begin
                case (op.sub_sel)
                    2'b00:   y = a & b;
                    2'b01:   y = a | b;
                    2'b10:   y = a ^ b;
                    default: y = ~a;
                endcase
            end
            MAIN_SHR: y = a >> 1;
            default:  y = a << 1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters via request/response handshakes.
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [9:0]          req_op,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_zero,
    output logic                busy,
    output logic [CNT_W-1:0]    ops_done,
    output state_t              fsm_state
);

    state_t             state;
    logic               ptr;
    logic               owner;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    op_t                op_q;
    logic [DATA_W-1:0]  alu_y;
    logic [1:0]         grant;
    logic               win;

    // Only IDLE grants; with both requests valid the pointer picks the winner.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign win       = grant[1];
    assign req_ready = grant;
    assign fsm_state = state;

    ALU #(.W(DATA_W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        a_q   <= win ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
                        b_q   <= win ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
                        op_q  <= win ? op_t'(req_op[9:5]) : op_t'(req_op[4:0]);
                        owner <= win;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_zero  <= (alu_y == '0);
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if ((rsp_valid & rsp_ready) != 2'b00) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        ops_done  <= ops_done + CNT_W'(1);
                        ptr       <= ~owner;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter against a behavioural ALU/arbitration reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DATA_W  = 4;
    localparam int CNT_W   = 2;
    localparam int MOD     = 1 << DATA_W;
    localparam int CNT_MOD = 1 << CNT_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          req_valid = 2'b00;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_a = '0;
    logic [2*DATA_W-1:0] req_b = '0;
    logic [9:0]          req_op = '0;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready = 2'b00;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_zero;
    logic                busy;
    logic [CNT_W-1:0]    ops_done;
    state_t              fsm_state;

    int total = 0;
    int bad = 0;

    bit               p_v[2];
    logic [DATA_W-1:0] p_a[2];
    logic [DATA_W-1:0] p_b[2];
    logic [4:0]        p_op[2];
    int m_ptr = 0;
    int m_ops = 0;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .busy      (busy),
        .ops_done  (ops_done),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] mk_op(input int m, input int s, input int c);
        logic [1:0] mm;
        logic [1:0] ss;
        logic       cc;
        mm = 2'(m);
        ss = 2'(s);
        cc = 1'(c);
        return {mm, ss, cc};
    endfunction

    // Reference ALU in plain integer arithmetic, reduced modulo 2^DATA_W.
    function automatic int ref_alu(input int a, input int b, input logic [4:0] op);
        int main_sel;
        int sub_sel;
        int cin;
        int r;
        main_sel = int'(op[4:3]);
        sub_sel  = int'(op[2:1]);
        cin      = int'(op[0]);
        r = 0;
        case (main_sel)
            0: case (sub_sel)
                0: r = a + cin;
                1: r = a + b + cin;
                2: r = a + (MOD - 1 - b) + cin;
                default: r = a + (MOD - 1) + cin;
            endcase
            1: case (sub_sel)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                default: r = MOD - 1 - a;
            endcase
            2: r = a / 2;
            default: r = a * 2;
        endcase
        return r % MOD;
    endfunction

    task automatic drive_reqs();
        req_valid = {p_v[1], p_v[0]};
        req_a     = {p_a[1], p_a[0]};
        req_b     = {p_b[1], p_b[0]};
        req_op    = {p_op[1], p_op[0]};
    endtask

    task automatic set_req(input int i, input int a, input int b, input logic [4:0] op);
        p_v[i]  = 1'b1;
        p_a[i]  = DATA_W'(a);
        p_b[i]  = DATA_W'(b);
        p_op[i] = op;
    endtask

    task automatic clear_reqs();
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        drive_reqs();
    endtask

    task automatic rand_fill(input int i);
        set_req(i, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
                5'($urandom_range(0, 31)));
    endtask

    // Runs one full transaction from grant to response handshake; entered and left 1ns after a rising edge.
    task automatic serve_one(input int delay, input bit refill);
        int w;
        int exp_d;
        logic [1:0] exp_mask;
        drive_reqs();
        w = (p_v[0] && p_v[1]) ? m_ptr : (p_v[1] ? 1 : 0);
        exp_mask = (w == 1) ? 2'b10 : 2'b01;
        exp_d = ref_alu(int'(p_a[w]), int'(p_b[w]), p_op[w]);
        @(negedge clk);
        total++;
        if (req_ready !== exp_mask) begin
            bad++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_mask);
        end
        @(posedge clk); #1;
        p_v[w] = 1'b0;
        drive_reqs();
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL exec: busy=%b rsp_valid=%b req_ready=%b expected 1 00 00",
                     busy, rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        if (refill) begin
            for (int i = 0; i < 2; i++)
                if (!p_v[i] && $urandom_range(0, 1) == 1) rand_fill(i);
            drive_reqs();
        end
        for (int k = 0; k <= delay; k++) begin
            if (k == delay) rsp_ready = exp_mask;
            @(negedge clk);
            total++;
            if (rsp_valid !== exp_mask || rsp_data !== DATA_W'(exp_d) ||
                rsp_zero !== (exp_d == 0) || req_ready !== 2'b00 || busy !== 1'b1) begin
                bad++;
                $display("FAIL resp: valid=%b data=%0d zero=%b req_ready=%b busy=%b expected %b %0d %b 00 1",
                         rsp_valid, rsp_data, rsp_zero, req_ready, busy, exp_mask, exp_d, exp_d == 0);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b00;
        m_ops = (m_ops + 1) % CNT_MOD;
        m_ptr = 1 - w;
        total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== CNT_W'(m_ops) || fsm_state !== IDLE) begin
            bad++;
            $display("FAIL done: valid=%b busy=%b ops_done=%0d state=%0d expected 00 0 %0d IDLE",
                     rsp_valid, busy, ops_done, fsm_state, m_ops);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_reqs();
        rsp_ready = 2'b00;
        m_ptr = 0;
        m_ops = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_data !== '0 || rsp_zero !== 1'b0 ||
            busy !== 1'b0 || ops_done !== '0 || fsm_state !== IDLE) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b data=%0d zero=%b busy=%b ops=%0d state=%0d expected all zero/IDLE",
                     req_ready, rsp_valid, rsp_data, rsp_zero, busy, ops_done, fsm_state);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        set_req(0, 3, 2, mk_op(0, 1, 0));
        serve_one(0, 1'b0);
        total++;
        if (ops_done !== CNT_W'(1)) begin
            bad++;
            $display("FAIL single_add_count: ops_done=%0d expected 1", ops_done);
        end
    endtask

    task automatic test_contention();
        set_req(0, 3, 2, mk_op(0, 2, 1));
        set_req(1, 2, 0, mk_op(3, 0, 0));
        serve_one(0, 1'b0);
        serve_one(0, 1'b0);
        set_req(0, 5, 6, mk_op(0, 1, 1));
        set_req(1, 9, 3, mk_op(1, 2, 0));
        serve_one(1, 1'b0);
        serve_one(0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_req(1, 3, 0, mk_op(0, 3, 0));
        serve_one(5, 1'b0);
    endtask

    task automatic test_logic_zero();
        set_req(0, 1, 0, mk_op(1, 0, int'($urandom_range(0, 1))));
        serve_one(0, 1'b0);
        set_req(1, 1, 0, mk_op(1, 2, int'($urandom_range(0, 1))));
        serve_one(0, 1'b0);
        set_req(0, 0, 0, mk_op(2, 0, 0));
        serve_one(0, 1'b0);
        set_req(0, 15, 7, mk_op(3, 1, 1));
        serve_one(0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if (!p_v[0] && !p_v[1]) rand_fill($urandom_range(0, 1));
            if (!p_v[0] && $urandom_range(0, 2) == 0) rand_fill(0);
            if (!p_v[1] && $urandom_range(0, 2) == 0) rand_fill(1);
            serve_one($urandom_range(0, 3), 1'b1);
        end
        clear_reqs();
    endtask

    task automatic test_reset_exec();
        set_req(0, 7, 1, mk_op(0, 1, 0));
        drive_reqs();
        @(negedge clk);
        @(posedge clk); #1;
        clear_reqs();
        rst_n = 1'b0;
        m_ops = 0;
        m_ptr = 0;
        #1;
        total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== '0 || fsm_state !== IDLE) begin
            bad++;
            $display("FAIL reset_exec: vld=%b busy=%b ops=%0d state=%0d expected 00 0 0 IDLE",
                     rsp_valid, busy, ops_done, fsm_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_req(1, 4, 4, mk_op(0, 1, 1));
        serve_one(0, 1'b0);
    endtask

    task automatic test_wrap();
        test_reset();
        for (int n = 0; n < 5; n++) begin
            rand_fill(n % 2);
            serve_one(0, 1'b0);
        end
        total++;
        if (ops_done !== CNT_W'(1)) begin
            bad++;
            $display("FAIL wrap: ops_done=%0d expected 1", ops_done);
        end
    endtask

    initial begin
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_a[i]  = '0;
            p_b[i]  = '0;
            p_op[i] = '0;
        end
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_logic_zero();
        test_random();
        test_reset_exec();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
